// File: rtl/tx_iq_interp_pkg.sv
// Shared constants and types for the TX I/Q interpolator.
package tx_iq_interp_pkg;

  localparam int unsigned SAMPLE_W   = 16;
  localparam int unsigned FIFO_DEPTH = 4;

  typedef enum logic [2:0] {
    RATE_48K  = 3'd0,
    RATE_96K  = 3'd1,
    RATE_192K = 3'd2
  } rate_e;

  typedef struct packed {
    logic signed [SAMPLE_W-1:0] re;
    logic signed [SAMPLE_W-1:0] im;
  } iq_t;

  // Unsupported rate codes fall back to 48 kHz.
  function automatic logic [1:0] rate_eff(input logic [2:0] code);
    case (code)
      RATE_96K:  return 2'd1;
      RATE_192K: return 2'd2;
      default:   return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/iq_fifo.sv
// 4-deep I/Q sample FIFO; a push while full only lands if a pop frees a slot the same cycle.
module iq_fifo
  import tx_iq_interp_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic flush,
  input  logic push,
  input  logic pop,
  input  iq_t  din,
  output iq_t  dout,
  output logic full,
  output logic empty
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  iq_t           mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (!reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tx_iq_interp.sv
// I2S-rate to DUC-rate I/Q interpolator. Define TX_IQ_INTERP_EN for linear
// interpolation; otherwise a zero-order hold (output = current sample) is built.
module tx_iq_interp
  import tx_iq_interp_pkg::*;
#(
  parameter int unsigned LOG2_MAX = 5  // must be >= 2 so the 192k ratio is at least 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [2:0]                 s_rate,
  input  logic                       in_strobe,
  input  logic signed [SAMPLE_W-1:0] in_real,
  input  logic signed [SAMPLE_W-1:0] in_imag,
  input  logic                       out_req,
  output logic                       out_strobe,
  output logic signed [SAMPLE_W-1:0] out_real,
  output logic signed [SAMPLE_W-1:0] out_imag,
  input  logic                       clear_flags,
  output logic                       underflow,
  output logic                       overflow
);

  localparam int unsigned KW = $clog2(LOG2_MAX + 1);

  logic [2:0]          rate_q;
  logic [KW-1:0]       k;
  logic [LOG2_MAX-1:0] phase;
  logic [LOG2_MAX-1:0] wrap_phase;
  iq_t                 prev;
  iq_t                 cur;
  iq_t                 head;
  logic                rate_change;
  logic                wrap;
  logic                pop;
  logic                starve;
  logic                push_drop;
  logic                fifo_full;
  logic                fifo_empty;
  logic signed [SAMPLE_W-1:0] y_re;
  logic signed [SAMPLE_W-1:0] y_im;

  assign rate_change = (s_rate != rate_q);
  assign k           = KW'(LOG2_MAX) - KW'(rate_eff(rate_q));
  assign wrap_phase  = LOG2_MAX'((32'd1 << k) - 32'd1);
  assign wrap        = out_req && (phase == wrap_phase);
  assign pop         = wrap && !rate_change;
  assign starve      = pop && fifo_empty;
  // Full FIFO accepts a push only when the same cycle pops an entry.
  assign push_drop   = in_strobe && fifo_full && !pop && !rate_change;

  iq_fifo u_fifo (
    .clock (clock),
    .reset (reset),
    .flush (rate_change),
    .push  (in_strobe),
    .pop   (pop),
    .din   ({in_real, in_imag}),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef TX_IQ_INTERP_EN
  localparam int unsigned PW = SAMPLE_W + 2 + LOG2_MAX;

  // prev + ((cur - prev) * phase) >>> k, truncated back to sample width.
  function automatic logic signed [SAMPLE_W-1:0] lerp(
    input logic signed [SAMPLE_W-1:0] a,
    input logic signed [SAMPLE_W-1:0] b,
    input logic [LOG2_MAX-1:0]        ph,
    input logic [KW-1:0]              sh
  );
    logic signed [PW-1:0] diff;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] step;
    diff = PW'(b) - PW'(a);
    prod = diff * $signed(PW'(ph));
    step = prod >>> sh;
    return a + step[SAMPLE_W-1:0];
  endfunction

  assign y_re = lerp(prev.re, cur.re, phase, k);
  assign y_im = lerp(prev.im, cur.im, phase, k);
`else
  assign y_re = cur.re;
  assign y_im = cur.im;
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      rate_q     <= s_rate;
      phase      <= '0;
      prev       <= '0;
      cur        <= '0;
      out_strobe <= 1'b0;
      out_real   <= '0;
      out_imag   <= '0;
      underflow  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      rate_q     <= s_rate;
      out_strobe <= out_req;
      if (out_req) begin
        out_real <= y_re;
        out_imag <= y_im;
      end
      underflow <= starve | (underflow & ~clear_flags);
      overflow  <= push_drop | (overflow & ~clear_flags);
      if (rate_change) begin
        phase <= '0;
        prev  <= '0;
        cur   <= '0;
      end else if (out_req) begin
        if (wrap) begin
          phase <= '0;
          prev  <= cur;
          if (!fifo_empty) begin
            cur <= head;
          end
        end else begin
          phase <= phase + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tx_iq_interp.sv
// Directed bench for tx_iq_interp; expectations follow whichever output mode is compiled.
module tb_tx_iq_interp;

`ifdef TX_IQ_INTERP_EN
  localparam bit INTERP = 1'b1;
`else
  localparam bit INTERP = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [2:0]        s_rate = 3'd2;
  logic              in_strobe = 1'b0;
  logic signed [15:0] in_real = '0;
  logic signed [15:0] in_imag = '0;
  logic              out_req = 1'b0;
  logic              out_strobe;
  logic signed [15:0] out_real;
  logic signed [15:0] out_imag;
  logic              clear_flags = 1'b0;
  logic              underflow;
  logic              overflow;

  int total = 0;
  int bad   = 0;
  int lin [8] = '{-32768, -24577, -16385, -8193, -1, 8191, 16383, 24575};

  tx_iq_interp #(.LOG2_MAX(5)) dut (
    .clock       (clock),
    .reset       (reset),
    .s_rate      (s_rate),
    .in_strobe   (in_strobe),
    .in_real     (in_real),
    .in_imag     (in_imag),
    .out_req     (out_req),
    .out_strobe  (out_strobe),
    .out_real    (out_real),
    .out_imag    (out_imag),
    .clear_flags (clear_flags),
    .underflow   (underflow),
    .overflow    (overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input int re, input int im);
    in_strobe = 1'b1;
    in_real   = 16'(re);
    in_imag   = 16'(im);
    cyc();
    in_strobe = 1'b0;
  endtask

  task automatic req();
    out_req = 1'b1;
    cyc();
    out_req = 1'b0;
  endtask

  task automatic clear();
    clear_flags = 1'b1;
    cyc();
    clear_flags = 1'b0;
  endtask

  task automatic do_reset(input logic [2:0] rate);
    reset  = 1'b0;
    s_rate = rate;
    cyc();
    cyc();
    reset = 1'b1;
  endtask

  initial begin
    // reset values while reset is held low
    cyc();
    cyc();
    check("rst_strobe", out_strobe, 0);
    check("rst_real", out_real, 0);
    check("rst_imag", out_imag, 0);
    check("rst_uf", underflow, 0);
    check("rst_of", overflow, 0);
    reset = 1'b1;

    // ramp 0 -> 800 at R=8
    push(0, 0);
    push(800, -800);
    repeat (16) req();
    check("a_strobe", out_strobe, 1);
    for (int p = 0; p < 8; p++) begin
      req();
      check("a_ramp_re", out_real, INTERP ? 100 * p : 800);
      check("a_ramp_im", out_imag, INTERP ? -100 * p : -800);
    end
    cyc();
    check("a_strobe_low", out_strobe, 0);
    check("a_hold", out_real, INTERP ? 700 : 800);
    check("a_uf", underflow, 1);

    // full-scale segment -32768 -> 32767
    do_reset(3'd2);
    push(-32768, 0);
    push(32767, 0);
    repeat (16) req();
    for (int p = 0; p < 8; p++) begin
      req();
      check("b_full", out_real, INTERP ? lin[p] : 32767);
    end

    // overflow: fifth push dropped, first four retained
    do_reset(3'd2);
    for (int i = 1; i <= 5; i++) push(100 * i, 0);
    check("c_of_set", overflow, 1);
    clear();
    check("c_of_clr", overflow, 0);
    for (int g = 1; g <= 6; g++) begin
      for (int p = 0; p < 8; p++) begin
        req();
        if (p == 0 && g >= 2)
          check("c_ph0", out_real, INTERP ? 100 * (g - 2) : ((g - 1) * 100 > 400 ? 400 : (g - 1) * 100));
        if (p == 4 && g == 6)
          check("c_ph4", out_real, 400);
      end
      if (g == 4) check("c_uf_lo", underflow, 0);
      if (g == 5) check("c_uf_hi", underflow, 1);
    end

    // underflow with coincident clear: set wins
    do_reset(3'd2);
    repeat (7) req();
    check("d_out", out_real, 0);
    check("d_uf_lo", underflow, 0);
    out_req     = 1'b1;
    clear_flags = 1'b1;
    cyc();
    out_req     = 1'b0;
    clear_flags = 1'b0;
    check("d_uf_win", underflow, 1);
    check("d_out2", out_real, 0);
    clear();
    check("d_uf_clr", underflow, 0);

    // rate change 48k -> 96k mid-stream
    do_reset(3'd0);
    push(1000, 0);
    push(2000, 0);
    repeat (35) req();
    s_rate = 3'd1;
    cyc();
    check("e_uf", underflow, 0);
    check("e_of", overflow, 0);
    push(1600, 0);
    req();
    check("e_first", out_real, 0);
    repeat (15) req();
    check("e_pre", out_real, 0);
    req();
    check("e_ph0", out_real, INTERP ? 0 : 1600);
    req();
    check("e_ph1", out_real, INTERP ? 100 : 1600);
    check("e_flags", {underflow, overflow}, 0);

    // reset in the cycle after a request
    do_reset(3'd2);
    push(500, 0);
    repeat (10) req();
    check("f_pre", out_real, INTERP ? 62 : 500);
    out_req = 1'b1;
    cyc();
    out_req = 1'b0;
    reset   = 1'b0;
    cyc();
    check("f_strobe", out_strobe, 0);
    check("f_real", out_real, 0);
    check("f_imag", out_imag, 0);
    reset = 1'b1;
    cyc();
    req();
    check("f_after", out_real, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
